// File: rtl/paddle_ctrl.sv
// paddle_ctrl: multi-paddle Pong controller. Each paddle moves under push
// buttons or follows the ball in auto mode, accelerating while a direction
// is held, and publishes its draw flag and edge coordinates.
module paddle_ctrl #(
  parameter int NUM_BARS    = 2,
  parameter int oLeft       = 10,
  parameter int xPitch      = 760,
  parameter int oTop        = 10,
  parameter int oHeight     = 50,
  parameter int oWidth      = 20,
  parameter int sWidth      = 800,
  parameter int sHeight     = 600,
  parameter int MAX_SPEED   = 4,
  parameter int ACCEL_TICKS = 8,
  parameter int DEADZONE    = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     PixelClock,
  input  logic [2*NUM_BARS-1:0]    Button,
  input  logic [NUM_BARS-1:0]      AutoMode,
  input  logic [10:0]              BallY,
  input  logic [11:0]              xPos,
  input  logic [11:0]              yPos,
  output logic [NUM_BARS-1:0]      drawBar,
  output logic [NUM_BARS*44-1:0]   barEdges,
  output logic [NUM_BARS-1:0]      moving
);

  localparam int SW = $clog2(MAX_SPEED + 1);
  localparam int HW = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
  localparam int HL = (ACCEL_TICKS >= 2) ? ACCEL_TICKS - 2 : 0;

  localparam logic [11:0] Y_MIN   = 12'd1;
  localparam logic [11:0] Y_MAX   = 12'(sHeight - oHeight);
  localparam logic signed [11:0] HALF_H = 12'(oHeight / 2);
  localparam logic signed [11:0] DZ     = 12'(DEADZONE);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN} dir_t;

  // Saturating upward move: the top edge never goes above row 1.
  function automatic logic [10:0] clamp_up(input logic [10:0] y, input logic [10:0] amt);
    logic [11:0] y12;
    logic [11:0] a12;
    y12 = {1'b0, y};
    a12 = {1'b0, amt};
    if (y12 < Y_MIN + a12) clamp_up = Y_MIN[10:0];
    else                   clamp_up = 11'(y12 - a12);
  endfunction

  // Saturating downward move: the bottom edge never goes below sHeight-1.
  function automatic logic [10:0] clamp_down(input logic [10:0] y, input logic [10:0] amt);
    logic [11:0] sum;
    sum = {1'b0, y} + {1'b0, amt};
    if (sum > Y_MAX) clamp_down = Y_MAX[10:0];
    else             clamp_down = sum[10:0];
  endfunction

  for (genvar i = 0; i < NUM_BARS; i++) begin : g_bar
    localparam logic [10:0] LEFT  = 11'(oLeft + i * xPitch);
    localparam logic [10:0] RIGHT = 11'(oLeft + i * xPitch + oWidth - 1);

    logic [10:0]          rect_y;
    dir_t                 state;
    logic [SW-1:0]        speed;
    logic [HW-1:0]        hold;
    logic                 moving_r;
    dir_t                 req;
    logic [10:0]          amt;
    logic [10:0]          y_next;
    logic                 wrap;
    logic [10:0]          bottom;
    logic signed [11:0]   centre;
    logic signed [11:0]   ball;

    // Decode the per-paddle request from buttons or from ball tracking.
    always_comb begin
      req    = IDLE;
      centre = signed'({1'b0, rect_y}) + HALF_H;
      ball   = signed'({1'b0, BallY});
      if (AutoMode[i]) begin
        if (ball < centre - DZ)      req = MOVE_UP;
        else if (ball > centre + DZ) req = MOVE_DOWN;
      end else begin
        case (Button[2*i +: 2])
          2'b01:   req = MOVE_UP;
          2'b10:   req = MOVE_DOWN;
          default: req = IDLE;
        endcase
      end
    end

    // Step size and next position; a fresh direction always starts at 1 pixel.
    always_comb begin
      amt    = (req == state) ? 11'(speed) : 11'd1;
      y_next = (req == MOVE_UP) ? clamp_up(rect_y, amt) : clamp_down(rect_y, amt);
      wrap   = (ACCEL_TICKS < 2) || (hold == HW'(HL));
    end

    // Direction FSM with position, acceleration and registered moving flag.
    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        rect_y   <= 11'(oTop);
        state    <= IDLE;
        speed    <= SW'(1);
        hold     <= '0;
        moving_r <= 1'b0;
      end else if (PixelClock) begin
        if (req == IDLE) begin
          state    <= IDLE;
          speed    <= SW'(1);
          hold     <= '0;
          moving_r <= 1'b0;
        end else begin
          rect_y   <= y_next;
          moving_r <= 1'b1;
          if (req == state) begin
            if (wrap) begin
              hold <= '0;
              if (speed < SW'(MAX_SPEED)) speed <= speed + SW'(1);
            end else begin
              hold <= hold + HW'(1);
            end
          end else begin
            state <= req;
            speed <= SW'(1);
            hold  <= '0;
          end
        end
      end
    end

    assign bottom               = rect_y + 11'(oHeight - 1);
    assign barEdges[44*i +: 44] = {bottom, rect_y, RIGHT, LEFT};
    assign moving[i]            = moving_r;
    assign drawBar[i]           = (xPos >= {1'b0, LEFT})   && (xPos <= {1'b0, RIGHT}) &&
                                  (yPos >= {1'b0, rect_y}) && (yPos <= {1'b0, bottom});
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: scoreboard bench for paddle_ctrl with a behavioural
// model of the two default paddles.
module tb_paddle_ctrl;
  localparam int NB = 2;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          PixelClock = 1'b0;
  logic [3:0]    Button = '0;
  logic [1:0]    AutoMode = '0;
  logic [10:0]   BallY = '0;
  logic [11:0]   xPos = '0;
  logic [11:0]   yPos = '0;
  logic [1:0]    drawBar;
  logic [87:0]   barEdges;
  logic [1:0]    moving;

  paddle_ctrl dut (
    .Clock(Clock), .Reset(Reset), .PixelClock(PixelClock), .Button(Button),
    .AutoMode(AutoMode), .BallY(BallY), .xPos(xPos), .yPos(yPos),
    .drawBar(drawBar), .barEdges(barEdges), .moving(moving)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;
  int probe_k  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Behavioural model: position, direction (0 none, 1 up, 2 down), speed, hold.
  int my[NB], mst[NB], msp[NB], mh[NB];

  typedef struct {
    logic [87:0] edges;
    logic [1:0]  mov;
    logic [1:0]  draw;
  } exp_t;
  exp_t sb[$];

  function automatic logic [43:0] exp_edges(input int p);
    int left;
    left = 10 + 760 * p;
    return {11'(my[p] + 49), 11'(my[p]), 11'(left + 19), 11'(left)};
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < NB; p++) begin
      my[p] = 10; mst[p] = 0; msp[p] = 1; mh[p] = 0;
    end
  endfunction

  function automatic int model_req(input int p);
    int c;
    if (AutoMode[p]) begin
      c = my[p] + 25;
      if (int'(BallY) < c - 4) return 1;
      if (int'(BallY) > c + 4) return 2;
      return 0;
    end
    if (Button[2*p] && !Button[2*p+1]) return 1;
    if (Button[2*p+1] && !Button[2*p]) return 2;
    return 0;
  endfunction

  function automatic void model_step();
    int r, amt;
    for (int p = 0; p < NB; p++) begin
      r = model_req(p);
      amt = 0;
      if (r == 0) begin
        mst[p] = 0; msp[p] = 1; mh[p] = 0;
      end else if (r == mst[p]) begin
        amt = msp[p];
        mh[p]++;
        if (mh[p] == 7) begin
          mh[p] = 0;
          if (msp[p] < 4) msp[p]++;
        end
      end else begin
        mst[p] = r; amt = 1; msp[p] = 1; mh[p] = 0;
      end
      if (r == 1) my[p] = (my[p] - amt < 1) ? 1 : my[p] - amt;
      if (r == 2) my[p] = (my[p] + amt > 550) ? 550 : my[p] + amt;
    end
  endfunction

  // One PixelClock step: drive, predict, then compare once the edge has passed.
  task automatic step(input logic [3:0] btn, input logic [1:0] am, input logic [10:0] ball);
    exp_t e, g;
    int px, left;
    @(negedge Clock);
    Button = btn; AutoMode = am; BallY = ball; PixelClock = 1'b1;
    model_step();
    px   = (probe_k >> 1) & 1;
    left = 10 + 760 * px;
    xPos = 12'(left + 5);
    yPos = (probe_k & 1) ? 12'(my[px] + 50) : 12'(my[px] + 49);
    probe_k++;
    e.edges = {exp_edges(1), exp_edges(0)};
    for (int p = 0; p < NB; p++) begin
      e.mov[p]  = (mst[p] != 0);
      e.draw[p] = (int'(xPos) >= 10 + 760 * p) && (int'(xPos) <= 29 + 760 * p) &&
                  (int'(yPos) >= my[p]) && (int'(yPos) <= my[p] + 49);
    end
    sb.push_back(e);
    @(posedge Clock);
    #1 PixelClock = 1'b0;
    g = sb.pop_front();
    check_val("edges0", 64'(barEdges[43:0]), 64'(g.edges[43:0]));
    check_val("edges1", 64'(barEdges[87:44]), 64'(g.edges[87:44]));
    check_val("moving", 64'(moving), 64'(g.mov));
    check_val("draw", 64'(drawBar), 64'(g.draw));
  endtask

  // Drive paddle p to an exact row, dropping to idle when the next stride overshoots.
  task automatic move_to(input int p, input int target);
    int guard, nm;
    logic [3:0] btn;
    guard = 0;
    while (my[p] != target && guard < 600) begin
      btn = '0;
      if (target > my[p]) begin
        nm = (mst[p] == 2) ? msp[p] : 1;
        if (target - my[p] >= nm) btn[2*p+1] = 1'b1;
      end else begin
        nm = (mst[p] == 1) ? msp[p] : 1;
        if (my[p] - target >= nm) btn[2*p] = 1'b1;
      end
      step(btn, 2'b00, 11'd0);
      guard++;
    end
    if (guard >= 600) begin
      n_checks++;
      $display("FAIL move_to paddle=%0d got=%0d exp=%0d", p, my[p], target);
    end
  endtask

  function automatic logic [10:0] top_of(input int p);
    return barEdges[44*p + 22 +: 11];
  endfunction

  function automatic logic [10:0] bot_of(input int p);
    return barEdges[44*p + 33 +: 11];
  endfunction

  initial begin
    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    check_val("rst_moving", 64'(moving), 64'd0);
    check_val("rst_edges0", 64'(barEdges[43:0]), 64'({11'd59, 11'd10, 11'd29, 11'd10}));
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check_val("init_edges0", 64'(barEdges[43:0]), 64'({11'd59, 11'd10, 11'd29, 11'd10}));
    check_val("init_edges1", 64'(barEdges[87:44]), 64'({11'd59, 11'd10, 11'd789, 11'd770}));
    check_val("init_moving", 64'(moving), 64'd0);
    xPos = 12'd15; yPos = 12'd30;
    #1 check_val("init_draw_in", 64'(drawBar[0]), 64'd1);
    xPos = 12'd30;
    #1 check_val("init_draw_out", 64'(drawBar[0]), 64'd0);

    // Buttons without PixelClock must not move anything.
    Button = 4'b1010;
    repeat (3) @(posedge Clock);
    #1 check_val("no_step_hold", 64'(top_of(0)), 64'd10);
    Button = '0;

    // Acceleration from rest at row 100.
    move_to(0, 100);
    step(4'b0000, 2'b00, 11'd0);
    for (int k = 1; k <= 8; k++) begin
      step(4'b0010, 2'b00, 11'd0);
      check_val("accel_top", 64'(top_of(0)), 64'(100 + k));
      check_val("accel_moving", 64'(moving[0]), 64'd1);
    end
    step(4'b0010, 2'b00, 11'd0);
    check_val("accel_speed2", 64'(top_of(0)), 64'd110);

    // Top clamp at full speed.
    move_to(0, 58);
    step(4'b0000, 2'b00, 11'd0);
    repeat (25) step(4'b0001, 2'b00, 11'd0);
    check_val("up_at3", 64'(top_of(0)), 64'd3);
    step(4'b0001, 2'b00, 11'd0);
    check_val("up_clamp_top", 64'(top_of(0)), 64'd1);
    check_val("up_clamp_bot", 64'(bot_of(0)), 64'd50);
    step(4'b0001, 2'b00, 11'd0);
    check_val("up_clamp_hold", 64'(top_of(0)), 64'd1);

    // Bottom clamp, then both buttons return to idle.
    move_to(0, 549);
    step(4'b0000, 2'b00, 11'd0);
    step(4'b0010, 2'b00, 11'd0);
    check_val("dn_top550", 64'(top_of(0)), 64'd550);
    step(4'b0010, 2'b00, 11'd0);
    check_val("dn_clamp_bot", 64'(bot_of(0)), 64'd599);
    step(4'b0011, 2'b00, 11'd0);
    check_val("both_idle", 64'(moving[0]), 64'd0);

    // Auto tracking ignores the buttons.
    move_to(0, 100);
    step(4'b0000, 2'b00, 11'd0);
    step(4'b0001, 2'b01, 11'd300);
    check_val("auto_down", 64'(top_of(0)), 64'd101);
    step(4'b0001, 2'b01, 11'd127);
    check_val("auto_dead_mov", 64'(moving[0]), 64'd0);
    check_val("auto_dead_top", 64'(top_of(0)), 64'd101);
    step(4'b0010, 2'b01, 11'd110);
    check_val("auto_up", 64'(top_of(0)), 64'd100);
    step(4'b0000, 2'b00, 11'd0);

    // Asynchronous reset in the middle of an accelerated move.
    repeat (16) step(4'b1000, 2'b00, 11'd0);
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    check_val("arst_top1", 64'(top_of(1)), 64'd10);
    check_val("arst_top0", 64'(top_of(0)), 64'd10);
    check_val("arst_moving", 64'(moving), 64'd0);
    model_reset();
    @(negedge Clock);
    Reset = 1'b1;
    step(4'b1000, 2'b00, 11'd0);
    check_val("post_rst_1", 64'(top_of(1)), 64'd11);
    step(4'b1000, 2'b00, 11'd0);
    check_val("post_rst_2", 64'(top_of(1)), 64'd12);

    // Opposite directions on both paddles at once.
    move_to(0, 300);
    step(4'b0000, 2'b00, 11'd0);
    repeat (12) step(4'b1001, 2'b00, 11'd0);
    check_val("opp_top0", 64'(top_of(0)), 64'd284);
    check_val("opp_top1", 64'(top_of(1)), 64'd28);
    check_val("opp_moving", 64'(moving), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", n_checks, 0);
    $fatal(1, "timeout");
  end
endmodule
